// File: rtl/wb_stage.sv
// Write-back stage: retires MEM-stage results into the register-file write port,
// waiting for the data-memory response on loads and aligning/extending load data.
module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [RD_WIDTH-1:0]   mem_rd,
    input  logic                  mem_rd_wen,
    input  logic                  mem_is_load,
    input  logic [2:0]            mem_funct3,
    input  logic [1:0]            mem_addr_lo,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wr_valid,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [RD_WIDTH-1:0]   rd_wb,
    output logic                  load_err
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_wr_valid;
    logic                  w_wr_valid_next;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] w_wr_data_next;
    logic [RD_WIDTH-1:0]   r_rd_wb;
    logic [RD_WIDTH-1:0]   w_rd_wb_next;
    logic                  r_load_err;
    logic                  w_load_err_next;

    logic [RD_WIDTH-1:0]   r_ld_rd;
    logic [RD_WIDTH-1:0]   w_ld_rd_next;
    logic                  r_ld_wen;
    logic                  w_ld_wen_next;
    logic [2:0]            r_ld_funct3;
    logic [2:0]            w_ld_funct3_next;
    logic [1:0]            r_ld_addr_lo;
    logic [1:0]            w_ld_addr_lo_next;

    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load_bad;

    // Lane selection from the word-aligned response using the latched address bits.
    assign w_byte = dmem_rdata[{r_ld_addr_lo, 3'b000} +: 8];
    assign w_half = dmem_rdata[{r_ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = dmem_rdata;
        case (r_ld_funct3)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        w_load_bad = 1'b0;
        case (r_ld_funct3)
            3'b001, 3'b101:         w_load_bad = r_ld_addr_lo[0];
            3'b010:                 w_load_bad = (r_ld_addr_lo != 2'b00);
            3'b011, 3'b110, 3'b111: w_load_bad = 1'b1;
            default:                w_load_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_wr_valid_next   = 1'b0;
        w_load_err_next   = 1'b0;
        w_wr_data_next    = r_wr_data;
        w_rd_wb_next      = r_rd_wb;
        w_ld_rd_next      = r_ld_rd;
        w_ld_wen_next     = r_ld_wen;
        w_ld_funct3_next  = r_ld_funct3;
        w_ld_addr_lo_next = r_ld_addr_lo;
        case (r_state)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        w_ld_rd_next      = mem_rd;
                        w_ld_wen_next     = mem_rd_wen;
                        w_ld_funct3_next  = mem_funct3;
                        w_ld_addr_lo_next = mem_addr_lo;
                        w_state_next      = WAIT_LOAD;
                    end else begin
                        w_wr_data_next  = mem_result;
                        w_rd_wb_next    = mem_rd;
                        w_wr_valid_next = mem_rd_wen && (mem_rd != '0);
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    w_state_next = IDLE;
                    if (w_load_bad) begin
                        w_load_err_next = 1'b1;
                    end else begin
                        w_wr_data_next  = w_load_data;
                        w_rd_wb_next    = r_ld_rd;
                        w_wr_valid_next = r_ld_wen && (r_ld_rd != '0);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state      <= IDLE;
            r_wr_valid   <= 1'b0;
            r_wr_data    <= '0;
            r_rd_wb      <= '0;
            r_load_err   <= 1'b0;
            r_ld_rd      <= '0;
            r_ld_wen     <= 1'b0;
            r_ld_funct3  <= 3'b000;
            r_ld_addr_lo <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_wr_valid   <= w_wr_valid_next;
            r_wr_data    <= w_wr_data_next;
            r_rd_wb      <= w_rd_wb_next;
            r_load_err   <= w_load_err_next;
            r_ld_rd      <= w_ld_rd_next;
            r_ld_wen     <= w_ld_wen_next;
            r_ld_funct3  <= w_ld_funct3_next;
            r_ld_addr_lo <= w_ld_addr_lo_next;
        end
    end

    assign mem_ready = (r_state == IDLE);
    assign wr_valid  = r_wr_valid;
    assign wr_data   = r_wr_data;
    assign rd_wb     = r_rd_wb;
    assign load_err  = r_load_err;

endmodule
